serial_adder: RTL and testbench

- Bit-serial, LSB-first N-bit adder: computes A + B + carry-in one bit per clock, using a single registered carry.
- Performs the additive counterpart of the team's combinational full-subtractor datapath.
- Sits beside the subtractor in the arithmetic lab set and serves area-constrained datapaths that trade latency for one full-adder cell.
- Start/busy/done handshake; result held stable until the next accepted start.

---
 rtl/arith_pkg.sv | 16 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 111 +++++++++++
 tb/tb_serial_adder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the bit-counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // A counter that walks 0..width-1 needs at least one bit, even for width 1.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder. This is the only adder cell in the serial datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_in_i,
  output logic sum_o,
  output logic c_out_o
);

  assign sum_o   = a_i ^ b_i ^ c_in_i;
  assign c_out_o = (a_i & b_i) | (c_in_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell and a registered carry,
// with a start/busy/done handshake. Results are held until the next result.
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_c_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_c_out
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               c_out_q, c_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fa_s, fa_c;

  full_adder u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (b_sh_q[0]),
    .c_in_i (carry_q),
    .sum_o  (fa_s),
    .c_out_o(fa_c)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          a_sh_d  = i_a;
          b_sh_d  = i_b;
          carry_d = i_c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        // Shift-then-insert keeps this legal for WIDTH == 1, where there is no [WIDTH-1:1] slice.
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = fa_s;
        carry_d             = fa_c;
        cnt_d               = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = sum_sh_d;
          c_out_d = fa_c;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the whole datapath is small flops, not a RAM, so every register is reset;
  // this also guarantees an in-flight operation leaves no trace after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_busy  = (state_q != IDLE);
  assign o_done  = (state_q == DONE);
  assign o_sum   = sum_q;
  assign o_c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked
// against an arithmetic reference {c_out, sum} = a + b + c_in.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic       sum1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } op_t;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .i_start(start8), .i_a(a8), .i_b(b8), .i_c_in(cin8),
    .o_busy(busy8), .o_done(done8), .o_sum(sum8), .o_c_out(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .i_start(start1), .i_a(a1), .i_b(b1), .i_c_in(cin1),
    .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_c_out(cout1)
  );

  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
    return 9'(a) + 9'(b) + 9'(cin);
  endfunction

  // One full operation on the WIDTH=8 instance; optionally checks handshake timing.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input string tag, input bit check_timing);
    logic [8:0] exp;
    logic [7:0] prev;
    int cyc, busy_cnt;
    bit got, held_ok;
    exp = ref_add(a, b, cin);
    @(negedge clk);
    prev = sum8;
    start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    busy_cnt = busy8 ? 1 : 0;
    cyc = 0; got = 1'b0; held_ok = 1'b1;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (busy8) busy_cnt++;
      if (done8) got = 1'b1;
      else if (sum8 !== prev) held_ok = 1'b0;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL %s done_timeout: no o_done within %0d cycles", tag, cyc);
    end
    checks++;
    if ({cout8, sum8} !== exp) begin
      errors++; $display("FAIL %s result: got c=%0b sum=%02h, expected c=%0b sum=%02h (a=%02h b=%02h cin=%0b)",
                         tag, cout8, sum8, exp[8], exp[7:0], a, b, cin);
    end
    @(posedge clk); #1;
    if (busy8) busy_cnt++;
    if (check_timing) begin
      checks++;
      if (cyc !== 8) begin
        errors++; $display("FAIL %s done_latency: got %0d cycles, expected 8", tag, cyc);
      end
      checks++;
      if (!held_ok) begin
        errors++; $display("FAIL %s sum_held_during_run: o_sum changed before o_done (prev=%02h)", tag, prev);
      end
      checks++;
      if (done8 !== 1'b0) begin
        errors++; $display("FAIL %s done_one_cycle: o_done=%0b after pulse, expected 0", tag, done8);
      end
      checks++;
      if (busy_cnt !== 9) begin
        errors++; $display("FAIL %s busy_cycles: got %0d, expected 9", tag, busy_cnt);
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: busy=%0b done=%0b, expected 0 0", busy8, done8);
    end
    checks++;
    if (sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++; $display("FAIL reset_result: sum=%02h c=%0b, expected 00 0", sum8, cout8);
    end
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 1'b0 || cout1 !== 1'b0) begin
      errors++; $display("FAIL reset_w1: busy=%0b done=%0b sum=%0b c=%0b, expected all 0",
                         busy1, done1, sum1, cout1);
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_directed();
    do_op(8'h3C, 8'h55, 1'b0, "dir_3c_55", 1'b1);
    do_op(8'hFF, 8'h01, 1'b0, "dir_ff_01", 1'b1);
    do_op(8'hFF, 8'hFF, 1'b1, "dir_ff_ff_c1", 1'b1);
  endtask

  task automatic test_ignore_start();
    int cyc, extra_done;
    bit got;
    @(negedge clk); start8 = 1'b1; a8 = 8'h3C; b8 = 8'h55; cin8 = 1'b0;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    @(posedge clk); #1; start8 = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1; cyc++;
      if (done8) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL ignore_done_timeout: no o_done within %0d cycles", cyc);
    end
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
    @(posedge clk); #1; start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0) begin
      errors++; $display("FAIL ignore_in_done: busy=%0b after DONE, expected 0", busy8);
    end
    checks++;
    if (sum8 !== 8'h91 || cout8 !== 1'b0) begin
      errors++; $display("FAIL ignore_result: sum=%02h c=%0b, expected 91 0", sum8, cout8);
    end
    extra_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8) extra_done++;
    end
    checks++;
    if (extra_done !== 0 || sum8 !== 8'h91) begin
      errors++; $display("FAIL ignore_no_extra: extra_done=%0d sum=%02h, expected 0 and 91", extra_done, sum8);
    end
  endtask

  task automatic test_reset_mid_run();
    int extra_done;
    @(negedge clk); start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); #2; reset_n = 1'b0;
    #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
      errors++; $display("FAIL reset_async: busy=%0b done=%0b sum=%02h c=%0b, expected all 0",
                         busy8, done8, sum8, cout8);
    end
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    extra_done = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8) extra_done++;
    end
    checks++;
    if (extra_done !== 0 || busy8 !== 1'b0 || sum8 !== 8'h00) begin
      errors++; $display("FAIL reset_discard: done_pulses=%0d busy=%0b sum=%02h, expected 0 0 00",
                         extra_done, busy8, sum8);
    end
    do_op(8'h3C, 8'h55, 1'b0, "after_reset", 1'b1);
  endtask

  task automatic test_back_to_back();
    op_t pend[$];
    int  accepts[$];
    op_t op;
    logic [8:0] exp, last;
    int cyc, results, bad_gap;
    bit have_last, held_ok;
    cyc = 0; results = 0; have_last = 1'b0; held_ok = 1'b1; last = '0;
    while (results < 5 && cyc < 100) begin
      @(negedge clk);
      start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      if (busy8 === 1'b0) begin
        op.a = a8; op.b = b8; op.cin = cin8;
        pend.push_back(op);
        accepts.push_back(cyc);
      end
      @(posedge clk); #1; cyc++;
      if (done8) begin
        checks++;
        if (pend.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_done at cycle %0d", cyc);
        end else begin
          op = pend.pop_front();
          exp = ref_add(op.a, op.b, op.cin);
          if ({cout8, sum8} !== exp) begin
            errors++; $display("FAIL b2b_result%0d: got c=%0b sum=%02h, expected c=%0b sum=%02h",
                               results, cout8, sum8, exp[8], exp[7:0]);
          end
          last = exp; have_last = 1'b1;
        end
        results++;
      end else if (have_last && {cout8, sum8} !== last) begin
        held_ok = 1'b0;
      end
    end
    start8 = 1'b0;
    checks++;
    if (results !== 5) begin
      errors++; $display("FAIL b2b_count: got %0d results in %0d cycles, expected 5", results, cyc);
    end
    checks++;
    if (!held_ok) begin
      errors++; $display("FAIL b2b_held: result changed between o_done pulses (last=%03h)", last);
    end
    bad_gap = 0;
    for (int i = 1; i < accepts.size(); i++)
      if (accepts[i] - accepts[i-1] != 10) bad_gap++;
    checks++;
    if (bad_gap !== 0 || accepts.size() < 5) begin
      errors++; $display("FAIL b2b_interval: %0d gaps not equal to 10 over %0d accepts", bad_gap, accepts.size());
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rand%0d", i), 1'b0);
  endtask

  task automatic test_width1();
    logic [1:0] exp;
    for (int k = 7; k >= 0; k--) begin
      logic [2:0] v;
      v = 3'(k);
      exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      @(negedge clk); start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      @(posedge clk); #1; start1 = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b1 || {cout1, sum1} !== exp) begin
        errors++; $display("FAIL w1_%0d%0d%0d: done=%0b c=%0b sum=%0b, expected done=1 c=%0b sum=%0b",
                           v[2], v[1], v[0], done1, cout1, sum1, exp[1], exp[0]);
      end
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
        errors++; $display("FAIL w1_return_idle: done=%0b busy=%0b, expected 0 0", done1, busy1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
